// File: rtl/ps2_ascii_fifo.sv
// PS/2 scan-code decoder that maps key presses to ASCII and buffers them in a show-ahead FIFO.
// Define REPEAT_FILTER_EN to suppress typematic repeats of the currently held key.
module ps2_ascii_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             inclock,
    input  logic             reset,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    input  logic             rd_en,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             overflow,
    output logic             shift_held,
    output logic [7:0]       last_data_received
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        BRK,
        EXT,
        EXT_BRK
    } dec_state_t;

    dec_state_t state, state_next;
    logic       shift_next;
    logic       is_make;
    logic       mapped;
    logic [7:0] ascii;
    logic       repeat_hit;
    logic       push_req;
    logic       do_push;
    logic       do_pop;
    logic       drop;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] head_idx;
    logic [7:0]       head_next;
    logic [CNT_W-1:0] count_next;

    always_ff @(posedge inclock) begin
        if (reset) begin
            state      <= IDLE;
            shift_held <= 1'b0;
        end else begin
            state      <= state_next;
            shift_held <= shift_next;
        end
    end

    always_comb begin
        state_next = state;
        shift_next = shift_held;
        is_make    = 1'b0;
        if (byte_valid) begin
            case (state)
                IDLE: begin
                    if (byte_in == 8'hE0)
                        state_next = EXT;
                    else if (byte_in == 8'hF0)
                        state_next = BRK;
                    else if (byte_in == 8'h12 || byte_in == 8'h59)
                        shift_next = 1'b1;
                    else
                        is_make = 1'b1;
                end
                BRK: begin
                    if (byte_in == 8'h12 || byte_in == 8'h59)
                        shift_next = 1'b0;
                    state_next = IDLE;
                end
                EXT: begin
                    if (byte_in == 8'hF0)
                        state_next = EXT_BRK;
                    else
                        state_next = IDLE;
                end
                EXT_BRK: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Letters follow shift; space, CR and backspace are the same either way.
    always_comb begin
        mapped = 1'b1;
        ascii  = 8'h00;
        case (byte_in)
            8'h1C: ascii = shift_held ? 8'h41 : 8'h61;
            8'h32: ascii = shift_held ? 8'h42 : 8'h62;
            8'h21: ascii = shift_held ? 8'h43 : 8'h63;
            8'h15: ascii = shift_held ? 8'h51 : 8'h71;
            8'h29: ascii = 8'h20;
            8'h5A: ascii = 8'h0D;
            8'h66: ascii = 8'h08;
            default: mapped = 1'b0;
        endcase
    end

`ifdef REPEAT_FILTER_EN
    logic [7:0] held_code;

    assign repeat_hit = (byte_in == held_code);

    always_ff @(posedge inclock) begin
        if (reset)
            held_code <= 8'h00;
        else if (is_make && mapped)
            held_code <= byte_in;
        else if (byte_valid && state == BRK && byte_in == held_code)
            held_code <= 8'h00;
    end
`else
    assign repeat_hit = 1'b0;
`endif

    assign push_req = is_make && mapped && !repeat_hit;
    assign do_pop   = rd_en && rd_valid;
    assign do_push  = push_req && (!full || do_pop);
    assign drop     = push_req && full && !do_pop;

    assign count_next = count + CNT_W'(do_push) - CNT_W'(do_pop);

    // The next head may be the very slot being written this edge, so bypass the write data.
    always_comb begin
        head_idx  = do_pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        head_next = (do_push && head_idx == wr_ptr) ? ascii : mem[head_idx];
    end

    always_ff @(posedge inclock) begin
        if (do_push)
            mem[wr_ptr] <= ascii;
    end

    always_ff @(posedge inclock) begin
        if (reset) begin
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            count              <= '0;
            full               <= 1'b0;
            rd_valid           <= 1'b0;
            overflow           <= 1'b0;
            rd_data            <= 8'h00;
            last_data_received <= 8'h00;
        end else begin
            if (do_push) begin
                wr_ptr             <= wr_ptr + PTR_W'(1);
                last_data_received <= ascii;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count    <= count_next;
            full     <= (count_next == CNT_W'(FIFO_DEPTH));
            rd_valid <= (count_next != '0);
            if (count_next != '0)
                rd_data <= head_next;
            if (drop)
                overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_ascii_fifo.sv
// Table-driven bench for ps2_ascii_fifo at FIFO_DEPTH=4, plus hand-written reset and repeat sequences.
module tb_ps2_ascii_fifo;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          inclock = 1'b0;
    logic          reset;
    logic [7:0]    byte_in;
    logic          byte_valid;
    logic          rd_en;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic [CW-1:0] count;
    logic          full;
    logic          overflow;
    logic          shift_held;
    logic [7:0]    last_data_received;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       bv;
        logic [7:0] b;
        logic       rd;
        int         cnt;
        logic       valid;
        logic [7:0] data;
        logic       full;
        logic       ovf;
        logic       shift;
        logic [7:0] last;
    } vec_t;

    vec_t vecs[$];

    ps2_ascii_fifo #(.FIFO_DEPTH(DEPTH)) dut (
        .inclock           (inclock),
        .reset             (reset),
        .byte_in           (byte_in),
        .byte_valid        (byte_valid),
        .rd_en             (rd_en),
        .rd_data           (rd_data),
        .rd_valid          (rd_valid),
        .count             (count),
        .full              (full),
        .overflow          (overflow),
        .shift_held        (shift_held),
        .last_data_received(last_data_received)
    );

    always #5 inclock = ~inclock;

    function automatic void add_vec(input logic bv, input logic [7:0] b, input logic rd,
                                    input int cnt, input logic valid, input logic [7:0] data,
                                    input logic fl, input logic ovf, input logic sh,
                                    input logic [7:0] last);
        vec_t v;
        v.bv = bv; v.b = b; v.rd = rd;
        v.cnt = cnt; v.valid = valid; v.data = data;
        v.full = fl; v.ovf = ovf; v.shift = sh; v.last = last;
        vecs.push_back(v);
    endfunction

    // Inputs are driven just after a rising edge and outputs checked just after the next one.
    task automatic applyStimulus(input logic bv, input logic [7:0] b, input logic rd);
        byte_valid = bv;
        byte_in    = b;
        rd_en      = rd;
        @(posedge inclock);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    initial begin
        int exp_entries;

        reset      = 1'b1;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        rd_en      = 1'b0;
        repeat (2) @(posedge inclock);
        #1;
        checkOutput("reset count", int'(count), 0);
        checkOutput("reset rd_valid", int'(rd_valid), 0);
        checkOutput("reset rd_data", int'(rd_data), 8'h00);
        checkOutput("reset full", int'(full), 0);
        checkOutput("reset overflow", int'(overflow), 0);
        checkOutput("reset shift", int'(shift_held), 0);
        checkOutput("reset last", int'(last_data_received), 8'h00);
        reset = 1'b0;

        // a press and release -> one 'a'
        add_vec(1, 8'h1C, 0, 1, 1, 8'h61, 0, 0, 0, 8'h61);
        add_vec(1, 8'hF0, 0, 1, 1, 8'h61, 0, 0, 0, 8'h61);
        add_vec(1, 8'h1C, 0, 1, 1, 8'h61, 0, 0, 0, 8'h61);
        add_vec(0, 8'h00, 1, 0, 0, 8'h61, 0, 0, 0, 8'h61);
        // shift B, release B, release shift, b
        add_vec(1, 8'h12, 0, 0, 0, 8'h61, 0, 0, 1, 8'h61);
        add_vec(1, 8'h32, 0, 1, 1, 8'h42, 0, 0, 1, 8'h42);
        add_vec(1, 8'hF0, 0, 1, 1, 8'h42, 0, 0, 1, 8'h42);
        add_vec(1, 8'h32, 0, 1, 1, 8'h42, 0, 0, 1, 8'h42);
        add_vec(1, 8'hF0, 0, 1, 1, 8'h42, 0, 0, 1, 8'h42);
        add_vec(1, 8'h12, 0, 1, 1, 8'h42, 0, 0, 0, 8'h42);
        add_vec(1, 8'h32, 0, 2, 1, 8'h42, 0, 0, 0, 8'h62);
        add_vec(1, 8'hF0, 0, 2, 1, 8'h42, 0, 0, 0, 8'h62);
        add_vec(1, 8'h32, 0, 2, 1, 8'h42, 0, 0, 0, 8'h62);
        add_vec(0, 8'h00, 1, 1, 1, 8'h62, 0, 0, 0, 8'h62);
        add_vec(0, 8'h00, 1, 0, 0, 8'h62, 0, 0, 0, 8'h62);
        // extended make/break are swallowed, then space
        add_vec(1, 8'hE0, 0, 0, 0, 8'h62, 0, 0, 0, 8'h62);
        add_vec(1, 8'h75, 0, 0, 0, 8'h62, 0, 0, 0, 8'h62);
        add_vec(1, 8'hE0, 0, 0, 0, 8'h62, 0, 0, 0, 8'h62);
        add_vec(1, 8'hF0, 0, 0, 0, 8'h62, 0, 0, 0, 8'h62);
        add_vec(1, 8'h75, 0, 0, 0, 8'h62, 0, 0, 0, 8'h62);
        add_vec(1, 8'h29, 0, 1, 1, 8'h20, 0, 0, 0, 8'h20);
        add_vec(1, 8'hF0, 0, 1, 1, 8'h20, 0, 0, 0, 8'h20);
        add_vec(1, 8'h29, 0, 1, 1, 8'h20, 0, 0, 0, 8'h20);
        // unmapped key S
        add_vec(1, 8'h1B, 0, 1, 1, 8'h20, 0, 0, 0, 8'h20);
        add_vec(1, 8'hF0, 0, 1, 1, 8'h20, 0, 0, 0, 8'h20);
        add_vec(1, 8'h1B, 0, 1, 1, 8'h20, 0, 0, 0, 8'h20);
        add_vec(0, 8'h00, 1, 0, 0, 8'h20, 0, 0, 0, 8'h20);
        add_vec(0, 8'h00, 1, 0, 0, 8'h20, 0, 0, 0, 8'h20);
        // five presses of a into a 4-deep FIFO
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 3; j++)
                add_vec(1, (j == 1) ? 8'hF0 : 8'h1C, 0, (k < 4) ? k + 1 : 4, 1, 8'h61,
                        (k >= 3), (k == 4), 0, 8'h61);
        end
        for (int k = 0; k < 4; k++)
            add_vec(0, 8'h00, 1, 3 - k, (k < 3), 8'h61, 0, 1, 0, 8'h61);
        add_vec(0, 8'h00, 1, 0, 0, 8'h61, 0, 1, 0, 8'h61);
        // refill, then push c coincident with a pop while full
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 3; j++)
                add_vec(1, (j == 1) ? 8'hF0 : 8'h1C, 0, k + 1, 1, 8'h61, (k == 3), 1, 0, 8'h61);
        end
        add_vec(1, 8'h21, 1, 4, 1, 8'h61, 1, 1, 0, 8'h63);
        add_vec(1, 8'hF0, 0, 4, 1, 8'h61, 1, 1, 0, 8'h63);
        add_vec(1, 8'h21, 0, 4, 1, 8'h61, 1, 1, 0, 8'h63);
        add_vec(0, 8'h00, 1, 3, 1, 8'h61, 0, 1, 0, 8'h63);
        add_vec(0, 8'h00, 1, 2, 1, 8'h61, 0, 1, 0, 8'h63);
        add_vec(0, 8'h00, 1, 1, 1, 8'h63, 0, 1, 0, 8'h63);
        add_vec(0, 8'h00, 1, 0, 0, 8'h63, 0, 1, 0, 8'h63);
        // push into empty with stray rd_en, then push+pop at count 1
        add_vec(1, 8'h5A, 1, 1, 1, 8'h0D, 0, 1, 0, 8'h0D);
        add_vec(1, 8'h66, 1, 1, 1, 8'h08, 0, 1, 0, 8'h08);
        add_vec(0, 8'h00, 1, 0, 0, 8'h08, 0, 1, 0, 8'h08);
        // right shift Q, release both, q
        add_vec(1, 8'h59, 0, 0, 0, 8'h08, 0, 1, 1, 8'h08);
        add_vec(1, 8'h15, 0, 1, 1, 8'h51, 0, 1, 1, 8'h51);
        add_vec(1, 8'hF0, 0, 1, 1, 8'h51, 0, 1, 1, 8'h51);
        add_vec(1, 8'h15, 0, 1, 1, 8'h51, 0, 1, 1, 8'h51);
        add_vec(1, 8'hF0, 0, 1, 1, 8'h51, 0, 1, 1, 8'h51);
        add_vec(1, 8'h59, 0, 1, 1, 8'h51, 0, 1, 0, 8'h51);
        add_vec(1, 8'h15, 0, 2, 1, 8'h51, 0, 1, 0, 8'h71);
        add_vec(1, 8'hF0, 0, 2, 1, 8'h51, 0, 1, 0, 8'h71);
        add_vec(1, 8'h15, 0, 2, 1, 8'h51, 0, 1, 0, 8'h71);
        add_vec(0, 8'h00, 1, 1, 1, 8'h71, 0, 1, 0, 8'h71);
        add_vec(0, 8'h00, 1, 0, 0, 8'h71, 0, 1, 0, 8'h71);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].bv, vecs[i].b, vecs[i].rd);
            checkOutput($sformatf("v%0d count", i), int'(count), vecs[i].cnt);
            checkOutput($sformatf("v%0d rd_valid", i), int'(rd_valid), int'(vecs[i].valid));
            checkOutput($sformatf("v%0d rd_data", i), int'(rd_data), int'(vecs[i].data));
            checkOutput($sformatf("v%0d full", i), int'(full), int'(vecs[i].full));
            checkOutput($sformatf("v%0d overflow", i), int'(overflow), int'(vecs[i].ovf));
            checkOutput($sformatf("v%0d shift", i), int'(shift_held), int'(vecs[i].shift));
            checkOutput($sformatf("v%0d last", i), int'(last_data_received), int'(vecs[i].last));
        end

        // reset right after F0 must drop the pending break, so the next 1C is a make
        applyStimulus(1, 8'hF0, 0);
        reset = 1'b1;
        applyStimulus(0, 8'h00, 0);
        checkOutput("midreset count", int'(count), 0);
        checkOutput("midreset overflow", int'(overflow), 0);
        checkOutput("midreset rd_data", int'(rd_data), 8'h00);
        checkOutput("midreset last", int'(last_data_received), 8'h00);
        reset = 1'b0;
        applyStimulus(1, 8'h1C, 0);
        checkOutput("post-reset make count", int'(count), 1);
        checkOutput("post-reset make data", int'(rd_data), 8'h61);
        applyStimulus(1, 8'hF0, 0);
        applyStimulus(1, 8'h1C, 0);
        applyStimulus(0, 8'h00, 1);
        checkOutput("post-reset drain", int'(count), 0);

        // typematic repeats of q
        applyStimulus(1, 8'h15, 0);
        applyStimulus(1, 8'h15, 0);
        applyStimulus(1, 8'h15, 0);
        applyStimulus(1, 8'hF0, 0);
        applyStimulus(1, 8'h15, 0);
        applyStimulus(1, 8'h15, 0);
`ifdef REPEAT_FILTER_EN
        exp_entries = 2;
`else
        exp_entries = 4;
`endif
        applyStimulus(0, 8'h00, 0);
        checkOutput("repeat count", int'(count), exp_entries);
        checkOutput("repeat overflow", int'(overflow), 0);
        for (int k = 0; k < exp_entries; k++) begin
            checkOutput($sformatf("repeat pop%0d data", k), int'(rd_data), 8'h71);
            applyStimulus(0, 8'h00, 1);
        end
        checkOutput("repeat drained", int'(count), 0);
        checkOutput("repeat drained valid", int'(rd_valid), 0);

        rd_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
